// File: rtl/alu_seq_if.sv
// alu_seq_if -- request/result bundle for the sequential ALU.
//   start, Op, A, B, c_in      : operation request (master -> slave)
//   R, zero, carry, sign,
//   overflow, busy, done       : registered result, flags and status (slave -> master)
interface alu_seq_if #(
    parameter int N = 4
);
    logic         start;
    logic [2:0]   Op;
    logic [N-1:0] A;
    logic [N-1:0] B;
    logic         c_in;
    logic [N-1:0] R;
    logic         zero;
    logic         carry;
    logic         sign;
    logic         overflow;
    logic         busy;
    logic         done;

    modport master (
        output start, Op, A, B, c_in,
        input  R, zero, carry, sign, overflow, busy, done
    );

    modport slave (
        input  start, Op, A, B, c_in,
        output R, zero, carry, sign, overflow, busy, done
    );
endinterface

// File: rtl/alu_seq.sv
// alu_seq -- N-bit ALU with single-cycle logic/arithmetic ops and multi-cycle
// MUL (shift-add) and SHL (one bit per cycle).
//   clk   : clock, rising edge
//   reset : asynchronous active-high reset
//   bus   : alu_seq_if.slave (request in, registered result/flags/status out)
//
// state | meaning
// IDLE  | waiting for start; single-cycle ops complete here
// EXEC  | iterating a MUL or SHL, busy high
module alu_seq #(
    parameter int N = 4
) (
    input  logic     clk,
    input  logic     reset,
    alu_seq_if.slave bus
);
    localparam int CW = $clog2(N);
    localparam logic [N-1:0] N_W = N'(N);
    localparam logic [N:0]   ONE_W = {{N{1'b0}}, 1'b1};

    typedef enum logic { IDLE, EXEC } state_t;

    state_t         state;
    logic           is_mul;
    logic [CW-1:0]  cnt;
    logic [2*N-1:0] acc;
    logic [2*N-1:0] mcand;
    logic [N-1:0]   mplier;
    logic [N-1:0]   sh;

    logic [N:0]     sum;
    logic [N-1:0]   res;
    logic           res_c;
    logic           res_v;
    logic [CW-1:0]  k;
    logic [2*N-1:0] mul_next;
    logic [N-1:0]   fin_r;
    logic           fin_c;
    logic           fin_v;

    // Single-cycle result straight from the request inputs.
    always_comb begin
        sum   = '0;
        res   = '0;
        res_c = 1'b0;
        res_v = 1'b0;
        case (bus.Op)
            3'b000: begin
                sum   = {1'b0, bus.A} + {1'b0, bus.B} + {{N{1'b0}}, bus.c_in};
                res   = sum[N-1:0];
                res_c = sum[N];
                res_v = (bus.A[N-1] == bus.B[N-1]) && (sum[N-1] != bus.A[N-1]);
            end
            3'b001: begin
                sum   = {1'b0, bus.A} + {1'b0, ~bus.B} + ONE_W;
                res   = sum[N-1:0];
                res_c = sum[N];
                res_v = (bus.A[N-1] != bus.B[N-1]) && (sum[N-1] != bus.A[N-1]);
            end
            3'b010:  res = bus.A & bus.B;
            3'b011:  res = bus.A | bus.B;
            3'b100:  res = bus.A ^ bus.B;
            3'b101:  res = ~bus.A;
            3'b111:  res = bus.A;   // only used when the shift count is zero
            default: res = '0;
        endcase
    end

    assign k = CW'(bus.B % N_W);

    // Final-iteration values for the multi-cycle ops.
    always_comb begin
        mul_next = acc + (mplier[0] ? mcand : '0);
        if (is_mul) begin
            fin_r = mul_next[N-1:0];
            fin_c = |mul_next[2*N-1:N];
            fin_v = |mul_next[2*N-1:N];
        end else begin
            fin_r = {sh[N-2:0], 1'b0};
            fin_c = sh[N-1];
            fin_v = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state        <= IDLE;
            is_mul       <= 1'b0;
            cnt          <= '0;
            acc          <= '0;
            mcand        <= '0;
            mplier       <= '0;
            sh           <= '0;
            bus.R        <= '0;
            bus.zero     <= 1'b0;
            bus.carry    <= 1'b0;
            bus.sign     <= 1'b0;
            bus.overflow <= 1'b0;
            bus.busy     <= 1'b0;
            bus.done     <= 1'b0;
        end else begin
            bus.done <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.start) begin
                        if (bus.Op == 3'b110) begin
                            state    <= EXEC;
                            bus.busy <= 1'b1;
                            is_mul   <= 1'b1;
                            acc      <= '0;
                            mcand    <= {{N{1'b0}}, bus.A};
                            mplier   <= bus.B;
                            cnt      <= CW'(N - 1);
                        end else if (bus.Op == 3'b111 && k != '0) begin
                            state    <= EXEC;
                            bus.busy <= 1'b1;
                            is_mul   <= 1'b0;
                            sh       <= bus.A;
                            cnt      <= k - CW'(1);
                        end else begin
                            bus.R        <= res;
                            bus.zero     <= (res == '0);
                            bus.sign     <= res[N-1];
                            bus.carry    <= res_c;
                            bus.overflow <= res_v;
                            bus.done     <= 1'b1;
                        end
                    end
                end
                EXEC: begin
                    acc    <= mul_next;
                    mcand  <= mcand << 1;
                    mplier <= mplier >> 1;
                    sh     <= sh << 1;
                    if (cnt == '0) begin
                        state        <= IDLE;
                        bus.busy     <= 1'b0;
                        bus.done     <= 1'b1;
                        bus.R        <= fin_r;
                        bus.zero     <= (fin_r == '0);
                        bus.sign     <= fin_r[N-1];
                        bus.carry    <= fin_c;
                        bus.overflow <= fin_v;
                    end else begin
                        cnt <= cnt - CW'(1);
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_alu_seq.sv
module tb_alu_seq;
    logic clk;
    logic reset;
    int   n_cmp;
    int   n_err;
    int   lat;
    int   busy_cnt;
    int   r_stable;
    int   dones;
    int   first_done;

    alu_seq_if #(.N(4)) bus ();
    alu_seq #(.N(4)) dut (.clk(clk), .reset(reset), .bus(bus));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp)
        else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Issues one request and waits (bounded) for done; operands are scrambled
    // right after the accepting edge so latching is exercised too.
    task automatic run_op(input logic [2:0] op, input logic [3:0] a, input logic [3:0] b,
                          input logic cin);
        logic [3:0] r0;
        @(negedge clk);
        r0         = bus.R;
        bus.start  = 1'b1;
        bus.Op     = op;
        bus.A      = a;
        bus.B      = b;
        bus.c_in   = cin;
        lat        = 0;
        busy_cnt   = 0;
        r_stable   = 1;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk);
            #1;
            bus.start = 1'b0;
            bus.A     = ~a;
            bus.B     = ~b;
            bus.c_in  = ~cin;
            lat++;
            if (bus.done) break;
            if (bus.busy) busy_cnt++;
            if (bus.R !== r0) r_stable = 0;
        end
        if (!bus.done) lat = -1;
    endtask

    task automatic check_res(input string tag, input logic [3:0] r, input logic z,
                             input logic c, input logic s, input logic v,
                             input int exp_lat, input int exp_busy);
        chk({tag, "_lat"}, lat, exp_lat);
        chk({tag, "_R"}, {28'd0, bus.R}, {28'd0, r});
        chk({tag, "_zero"}, {31'd0, bus.zero}, {31'd0, z});
        chk({tag, "_carry"}, {31'd0, bus.carry}, {31'd0, c});
        chk({tag, "_sign"}, {31'd0, bus.sign}, {31'd0, s});
        chk({tag, "_ovf"}, {31'd0, bus.overflow}, {31'd0, v});
        chk({tag, "_busy_cycles"}, busy_cnt, exp_busy);
        chk({tag, "_r_hold"}, r_stable, 1);
    endtask

    task automatic check_done_low(input string tag);
        @(posedge clk);
        #1;
        chk({tag, "_done_1cyc"}, {31'd0, bus.done}, 32'd0);
    endtask

    initial begin
        n_cmp     = 0;
        n_err     = 0;
        reset     = 1'b1;
        bus.start = 1'b0;
        bus.Op    = 3'b000;
        bus.A     = '0;
        bus.B     = '0;
        bus.c_in  = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_R", {28'd0, bus.R}, 32'd0);
        chk("rst_flags", {28'd0, bus.zero, bus.carry, bus.sign, bus.overflow}, 32'd0);
        chk("rst_busy_done", {30'd0, bus.busy, bus.done}, 32'd0);
        @(negedge clk);
        reset = 1'b0;

        run_op(3'b000, 4'b0111, 4'b0001, 1'b0);
        check_res("add_ovf", 4'b1000, 0, 0, 1, 1, 1, 0);
        check_done_low("add_ovf");

        run_op(3'b001, 4'b0011, 4'b0011, 1'b0);
        check_res("sub_zero", 4'b0000, 1, 1, 0, 0, 1, 0);

        // back-to-back: each run_op issues start in the previous done cycle
        run_op(3'b000, 4'b1111, 4'b0001, 1'b1);
        check_res("add_cin", 4'b0001, 0, 1, 0, 0, 1, 0);
        run_op(3'b001, 4'b0111, 4'b1000, 1'b0);
        check_res("sub_ovf", 4'b1111, 0, 0, 1, 1, 1, 0);
        run_op(3'b010, 4'b1100, 4'b1010, 1'b1);
        check_res("and", 4'b1000, 0, 0, 1, 0, 1, 0);
        run_op(3'b011, 4'b0000, 4'b0000, 1'b0);
        check_res("or_zero", 4'b0000, 1, 0, 0, 0, 1, 0);
        run_op(3'b100, 4'b1100, 4'b1010, 1'b0);
        check_res("xor", 4'b0110, 0, 0, 0, 0, 1, 0);
        run_op(3'b101, 4'b0101, 4'b0000, 1'b0);
        check_res("not", 4'b1010, 0, 0, 1, 0, 1, 0);

        run_op(3'b110, 4'b0101, 4'b0011, 1'b0);
        check_res("mul_15", 4'b1111, 0, 0, 1, 0, 5, 4);
        check_done_low("mul_15");
        run_op(3'b110, 4'b0110, 4'b0011, 1'b0);
        check_res("mul_ovf", 4'b0010, 0, 1, 0, 1, 5, 4);

        run_op(3'b111, 4'b0011, 4'b0011, 1'b0);
        check_res("shl_3", 4'b1000, 0, 1, 1, 0, 4, 3);
        check_done_low("shl_3");
        run_op(3'b111, 4'b0011, 4'b0100, 1'b0);
        check_res("shl_k0", 4'b0011, 0, 0, 0, 0, 1, 0);
        run_op(3'b111, 4'b1001, 4'b0001, 1'b0);
        check_res("shl_1", 4'b0010, 0, 1, 0, 0, 2, 1);

        // reset in the middle of a MUL
        run_op(3'b001, 4'b0111, 4'b1000, 1'b0);
        @(negedge clk);
        bus.start = 1'b1;
        bus.Op    = 3'b110;
        bus.A     = 4'b0101;
        bus.B     = 4'b0011;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        @(posedge clk);
        #2;
        reset = 1'b1;
        #1;
        chk("rstmid_R", {28'd0, bus.R}, 32'd0);
        chk("rstmid_flags", {28'd0, bus.zero, bus.carry, bus.sign, bus.overflow}, 32'd0);
        chk("rstmid_busy_done", {30'd0, bus.busy, bus.done}, 32'd0);
        @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        dones = 0;
        for (int i = 0; i < 8; i++) begin
            @(posedge clk);
            #1;
            if (bus.done) dones++;
        end
        chk("rstmid_no_done", dones, 0);
        run_op(3'b000, 4'b0010, 4'b0010, 1'b0);
        check_res("rstmid_add", 4'b0100, 0, 0, 0, 0, 1, 0);

        // start during MUL must be ignored
        @(negedge clk);
        bus.start = 1'b1;
        bus.Op    = 3'b110;
        bus.A     = 4'b0110;
        bus.B     = 4'b0011;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        @(negedge clk);
        bus.start = 1'b1;
        bus.Op    = 3'b000;
        bus.A     = 4'b0001;
        bus.B     = 4'b0001;
        @(posedge clk);
        #1;
        bus.start  = 1'b0;
        dones      = 0;
        first_done = -1;
        for (int i = 0; i < 10; i++) begin
            if (bus.done) begin
                dones++;
                if (first_done < 0) first_done = 2 + i;
            end
            @(posedge clk);
            #1;
        end
        chk("ign_done_count", dones, 1);
        chk("ign_latency", first_done, 5);
        chk("ign_R", {28'd0, bus.R}, 32'h2);
        chk("ign_carry_ovf", {30'd0, bus.carry, bus.overflow}, 32'h3);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
